// File: rtl/sample_interpolator_pkg.sv
// Shared audio-path definitions for the sample interpolator: widths, interpolation
// modes, FSM states and the per-burst configuration decode.
package sample_interpolator_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_HOLD = 2'b01,
        MODE_LIN  = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] factor;
        mode_e      mode;
        logic [1:0] shift;
    } burst_cfg_t;

    // Linear interpolation needs a power-of-two factor so the divide is a shift;
    // anything else (and the reserved mode 11) falls back to hold.
    function automatic burst_cfg_t decode_cfg(input logic [3:0] factor, input logic [1:0] mode);
        burst_cfg_t cfg;
        cfg.factor = (factor == 4'd0) ? 4'd1 : factor;
        cfg.mode   = MODE_HOLD;
        cfg.shift  = 2'd0;
        if (mode == MODE_ZERO) begin
            cfg.mode = MODE_ZERO;
        end else if (mode == MODE_LIN) begin
            case (cfg.factor)
                4'd1: begin cfg.mode = MODE_LIN; cfg.shift = 2'd0; end
                4'd2: begin cfg.mode = MODE_LIN; cfg.shift = 2'd1; end
                4'd4: begin cfg.mode = MODE_LIN; cfg.shift = 2'd2; end
                4'd8: begin cfg.mode = MODE_LIN; cfg.shift = 2'd3; end
                default: cfg.mode = MODE_HOLD;
            endcase
        end
        return cfg;
    endfunction

endpackage

// File: rtl/sample_interpolator_phase_calc.sv
// Combinational value of one output phase from the previous/current samples and phase index.
module interp_phase_calc
    import sample_interpolator_pkg::*;
(
    input  sample_t    i_prev,
    input  sample_t    i_cur,
    input  logic [3:0] i_k,
    input  mode_e      i_mode,
    input  logic [1:0] i_shift,
    output sample_t    o_value
);

    logic signed [16:0] w_delta;
    logic signed [20:0] w_prod;
    logic signed [20:0] w_scaled;
    logic signed [20:0] w_sum;

    // The interpolated value always lies between prev and cur, so truncating to 16 bits is lossless.
    assign w_delta  = $signed({i_cur[15], i_cur}) - $signed({i_prev[15], i_prev});
    assign w_prod   = $signed({{4{w_delta[16]}}, w_delta}) * $signed({17'd0, i_k});
    assign w_scaled = w_prod >>> i_shift;
    assign w_sum    = $signed({{5{i_prev[15]}}, i_prev}) + w_scaled;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        o_value = i_cur;
        case (i_mode)
            MODE_ZERO: o_value = (i_k == 4'd0) ? i_cur : '0;
            MODE_LIN:  o_value = w_sum[15:0];
            default:   o_value = i_cur;
        endcase
    end

endmodule

// File: rtl/sample_interpolator.sv
// Upsampler: one input sample per handshake, factor output samples per burst on out_tick,
// by zero-stuffing, zero-order hold or linear interpolation.
module sample_interpolator
    import sample_interpolator_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] datain,
    input  logic        datain_valid,
    output logic        datain_ready,
    input  logic [3:0]  factor,
    input  logic [1:0]  mode,
    input  logic        out_tick,
    output logic [15:0] dataout,
    output logic        dataout_valid,
    output logic        underrun
);

    state_e     r_state;
    state_e     w_state_next;
    sample_t    r_hold;
    logic       r_hold_full;
    sample_t    r_cur;
    sample_t    r_prev;
    logic [3:0] r_k;
    logic [3:0] r_f_l;
    mode_e      r_mode_l;
    logic [1:0] r_s_l;
    sample_t    r_dataout;
    logic       r_dataout_valid;
    logic       r_underrun;

    logic       w_xfer;
    logic       w_avail;
    sample_t    w_new;
    burst_cfg_t w_cfg;
    logic       w_last;
    logic       w_load;
    logic       w_fresh;
    logic       w_underrun;
    sample_t    w_calc_prev;
    sample_t    w_calc_cur;
    logic [3:0] w_calc_k;
    mode_e      w_calc_mode;
    logic [1:0] w_calc_shift;
    sample_t    w_phase_value;
    sample_t    w_out_value;

    assign datain_ready  = !r_hold_full;
    assign dataout       = r_dataout;
    assign dataout_valid = r_dataout_valid;
    assign underrun      = r_underrun;

    // A full hold register is always the next sample; otherwise a same-cycle transfer bypasses it.
    assign w_xfer  = datain_valid && !r_hold_full;
    assign w_avail = r_hold_full || w_xfer;
    assign w_new   = r_hold_full ? r_hold : datain;
    assign w_cfg   = decode_cfg(factor, mode);
    assign w_last  = (r_k == r_f_l - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        if (out_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_avail) begin
                        w_load       = 1'b1;
                        w_state_next = (w_cfg.factor == 4'd1) ? ST_IDLE : ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_last) begin
                        if (w_avail) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // A burst loaded from IDLE emits its phase 0 on the loading tick, so the calculator sees the new values.
    always_comb begin
        w_fresh      = w_load && (r_state == ST_IDLE);
        w_underrun   = out_tick && (r_state == ST_IDLE) && !w_avail;
        w_calc_prev  = w_fresh ? r_cur        : r_prev;
        w_calc_cur   = w_fresh ? w_new        : r_cur;
        w_calc_k     = w_fresh ? 4'd0         : r_k;
        w_calc_mode  = w_fresh ? w_cfg.mode   : r_mode_l;
        w_calc_shift = w_fresh ? w_cfg.shift  : r_s_l;
        w_out_value  = w_phase_value;
        if (w_underrun) begin
            w_out_value = (r_mode_l == MODE_ZERO) ? '0 : r_cur;
        end
    end

    interp_phase_calc u_phase_calc (
        .i_prev  (w_calc_prev),
        .i_cur   (w_calc_cur),
        .i_k     (w_calc_k),
        .i_mode  (w_calc_mode),
        .i_shift (w_calc_shift),
        .o_value (w_phase_value)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold          <= '0;
            r_hold_full     <= 1'b0;
            r_cur           <= '0;
            r_prev          <= '0;
            r_k             <= 4'd0;
            r_f_l           <= 4'd1;
            r_mode_l        <= MODE_HOLD;
            r_s_l           <= 2'd0;
            r_dataout       <= '0;
            r_dataout_valid <= 1'b0;
            r_underrun      <= 1'b0;
        end else begin
            if (w_xfer && !w_load) begin
                r_hold      <= datain;
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_prev   <= r_cur;
                r_cur    <= w_new;
                r_f_l    <= w_cfg.factor;
                r_mode_l <= w_cfg.mode;
                r_s_l    <= w_cfg.shift;
                r_k      <= (r_state == ST_IDLE) ? 4'd1 : 4'd0;
            end else if (out_tick && (r_state == ST_EMIT) && !w_last) begin
                r_k <= r_k + 4'd1;
            end

            r_dataout_valid <= out_tick;
            r_underrun      <= w_underrun;
            if (out_tick) begin
                r_dataout <= w_out_value;
            end
        end
    end

endmodule

// File: tb/tb_sample_interpolator.sv
// Directed self-checking bench for sample_interpolator: vector table plus a backpressure run.
module tb_sample_interpolator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] datain;
    logic        datain_valid;
    logic        datain_ready;
    logic [3:0]  factor;
    logic [1:0]  mode;
    logic        out_tick;
    logic [15:0] dataout;
    logic        dataout_valid;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic        tick;
        logic        vld;
        logic [15:0] din;
        logic [3:0]  fac;
        logic [1:0]  md;
        logic        exp_dv;
        logic [15:0] exp_d;
        logic        exp_ur;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[$];

    sample_interpolator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_ready  (datain_ready),
        .factor        (factor),
        .mode          (mode),
        .out_tick      (out_tick),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one clock's worth of inputs, then samples outputs 1 ns after the edge.
    task automatic step(input logic rst, input logic tick, input logic vld, input logic [15:0] d,
                        input logic [3:0] f, input logic [1:0] m);
        rst_n        = !rst;
        out_tick     = tick;
        datain_valid = vld;
        datain       = d;
        factor       = f;
        mode         = m;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic rst, input logic tick, input logic vld,
                       input logic [15:0] din, input logic [3:0] fac, input logic [1:0] md,
                       input logic edv, input logic [15:0] ed, input logic eur, input logic erdy);
        vec_t v;
        v.name = name; v.rst = rst; v.tick = tick; v.vld = vld; v.din = din; v.fac = fac; v.md = md;
        v.exp_dv = edv; v.exp_d = ed; v.exp_ur = eur; v.exp_rdy = erdy;
        vecs.push_back(v);
    endtask

    logic [15:0] acc[16];
    int          acc_cnt;
    int          out_n;
    logic        rdy_before;
    logic        tick_now;

    initial begin
        //   name         rst tick vld din       fac   md     dv ed        ur rdy
        add("reset",       1, 0, 0, 16'h0000, 4'd4, 2'd1,  0, 16'h0000, 0, 1);
        // hold, factor 4
        add("h_acc1",      0, 0, 1, 16'h1000, 4'd4, 2'd1,  0, 16'h0000, 0, 0);
        add("h_p0",        0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h1000, 0, 1);
        add("h_acc2",      0, 0, 1, 16'h2000, 4'd4, 2'd1,  0, 16'h0000, 0, 0);
        add("h_p1",        0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h1000, 0, 0);
        add("h_p2",        0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h1000, 0, 0);
        add("h_p3_load",   0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h1000, 0, 1);
        add("h_b2p0",      0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h2000, 0, 1);
        add("h_b2p1",      0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h2000, 0, 1);
        add("h_b2p2",      0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h2000, 0, 1);
        add("h_b2p3",      0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h2000, 0, 1);
        add("h_underrun",  0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h2000, 1, 1);
        // zero-stuff, factor 3, bypass load
        add("z_p0",        0, 1, 1, 16'h7FFF, 4'd3, 2'd0,  1, 16'h7FFF, 0, 1);
        add("z_p1",        0, 1, 0, 16'h0000, 4'd3, 2'd0,  1, 16'h0000, 0, 1);
        add("z_p2",        0, 1, 0, 16'h0000, 4'd3, 2'd0,  1, 16'h0000, 0, 1);
        add("z_underrun",  0, 1, 0, 16'h0000, 4'd3, 2'd0,  1, 16'h0000, 1, 1);
        add("z_quiet",     0, 0, 0, 16'h0000, 4'd3, 2'd0,  0, 16'h0000, 0, 1);
        // linear, factor 4
        add("l_reset",     1, 0, 0, 16'h0000, 4'd4, 2'd2,  0, 16'h0000, 0, 1);
        add("l_acc1",      0, 0, 1, 16'h0400, 4'd4, 2'd2,  0, 16'h0000, 0, 0);
        add("l_a0",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0000, 0, 1);
        add("l_a1_acc2",   0, 1, 1, 16'h0800, 4'd4, 2'd2,  1, 16'h0100, 0, 0);
        add("l_a2",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0200, 0, 0);
        add("l_a3_load",   0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0300, 0, 1);
        add("l_b0",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0400, 0, 1);
        add("l_b1",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0500, 0, 1);
        add("l_b2",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0600, 0, 1);
        add("l_b3",        0, 1, 0, 16'h0000, 4'd4, 2'd2,  1, 16'h0700, 0, 1);
        // linear negative, factor 2
        add("n_reset",     1, 0, 0, 16'h0000, 4'd2, 2'd2,  0, 16'h0000, 0, 1);
        add("n_p0",        0, 1, 1, 16'hFF00, 4'd2, 2'd2,  1, 16'h0000, 0, 1);
        add("n_p1",        0, 1, 0, 16'h0000, 4'd2, 2'd2,  1, 16'hFF80, 0, 1);
        add("n_underrun",  0, 1, 0, 16'h0000, 4'd2, 2'd2,  1, 16'hFF00, 1, 1);
        // factor 0 in hold acts as 1
        add("f0_p0",       0, 1, 1, 16'h1234, 4'd0, 2'd1,  1, 16'h1234, 0, 1);
        add("f0_underrun", 0, 1, 0, 16'h0000, 4'd0, 2'd1,  1, 16'h1234, 1, 1);
        // factor change mid-burst is ignored
        add("fc_p0",       0, 1, 1, 16'h0AAA, 4'd2, 2'd1,  1, 16'h0AAA, 0, 1);
        add("fc_p1",       0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h0AAA, 0, 1);
        add("fc_underrun", 0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h0AAA, 1, 1);
        // mode 11 acts as hold
        add("m3_p0",       0, 1, 1, 16'h0123, 4'd2, 2'd3,  1, 16'h0123, 0, 1);
        add("m3_p1",       0, 1, 0, 16'h0000, 4'd2, 2'd3,  1, 16'h0123, 0, 1);
        // linear with factor 3 acts as hold
        add("l3_p0",       0, 1, 1, 16'h0300, 4'd3, 2'd2,  1, 16'h0300, 0, 1);
        add("l3_p1",       0, 1, 0, 16'h0000, 4'd3, 2'd2,  1, 16'h0300, 0, 1);
        add("l3_p2",       0, 1, 0, 16'h0000, 4'd3, 2'd2,  1, 16'h0300, 0, 1);
        add("l3_underrun", 0, 1, 0, 16'h0000, 4'd3, 2'd2,  1, 16'h0300, 1, 1);
        // reset mid-burst discards the burst and the held sample
        add("r_p0",        0, 1, 1, 16'h5555, 4'd4, 2'd1,  1, 16'h5555, 0, 1);
        add("r_acc",       0, 0, 1, 16'h6666, 4'd4, 2'd1,  0, 16'h0000, 0, 0);
        add("r_reset",     1, 0, 0, 16'h0000, 4'd4, 2'd1,  0, 16'h0000, 0, 1);
        add("r_underrun",  0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h0000, 1, 1);
        add("r_new_p0",    0, 1, 1, 16'h7777, 4'd4, 2'd1,  1, 16'h7777, 0, 1);
        add("r_new_p1",    0, 1, 0, 16'h0000, 4'd4, 2'd1,  1, 16'h7777, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].tick, vecs[i].vld, vecs[i].din, vecs[i].fac, vecs[i].md);
            check({vecs[i].name, ".valid"}, {31'd0, dataout_valid}, {31'd0, vecs[i].exp_dv});
            if (vecs[i].exp_dv || vecs[i].rst) begin
                check({vecs[i].name, ".data"}, {16'd0, dataout}, {16'd0, vecs[i].exp_d});
            end
            check({vecs[i].name, ".underrun"}, {31'd0, underrun}, {31'd0, vecs[i].exp_ur});
            check({vecs[i].name, ".ready"}, {31'd0, datain_ready}, {31'd0, vecs[i].exp_rdy});
        end

        // Backpressure: valid held high, factor 8 hold, a tick every other cycle.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'd8, 2'd1);
        acc_cnt = 0;
        out_n   = 0;
        for (int i = 0; i < 128; i++) begin
            tick_now   = (i % 2) == 1;
            rdy_before = datain_ready;
            step(1'b0, tick_now, 1'b1, 16'h0100 + 16'(acc_cnt), 4'd8, 2'd1);
            if (rdy_before) begin
                acc[acc_cnt] = 16'h0100 + 16'(acc_cnt);
                acc_cnt++;
            end
            if (i == 0) begin
                check("bp.ready_low_after_accept", {31'd0, datain_ready}, 32'd0);
            end
            if (tick_now) begin
                check("bp.valid", {31'd0, dataout_valid}, 32'd1);
                check("bp.no_underrun", {31'd0, underrun}, 32'd0);
                check($sformatf("bp.out%0d", out_n), {16'd0, dataout}, {16'd0, acc[out_n / 8]});
                out_n++;
            end
        end
        check("bp.accept_count", acc_cnt, 32'd9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
